// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
// Optional feature: define ALU_ARB_ROUNDROBIN_EN for round-robin tie breaking.
package alu_arb_pkg;

    localparam int unsigned SEL_W = 2;

    localparam logic [SEL_W-1:0] OP_AND = 2'b00;
    localparam logic [SEL_W-1:0] OP_OR  = 2'b01;
    localparam logic [SEL_W-1:0] OP_XOR = 2'b10;
    localparam logic [SEL_W-1:0] OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arb_pick.sv
// Grant selection between two requesters.
// With ALU_ARB_ROUNDROBIN_EN a tie goes to the requester not granted last;
// without it a tie always goes to req0 and no pointer input exists.
module alu_arb_pick (
    input  logic valid0,
    input  logic valid1,
`ifdef ALU_ARB_ROUNDROBIN_EN
    input  logic last,
`endif
    output logic gnt0,
    output logic gnt1
);

    // One-hot grant from the current valids
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (valid0 && valid1) begin
`ifdef ALU_ARB_ROUNDROBIN_EN
            // last == 1 means req1 won the previous transfer
            gnt0 = last;
            gnt1 = !last;
`else
            gnt0 = 1'b1;
`endif
        end else begin
            gnt0 = valid0;
            gnt1 = valid1;
        end
    end

endmodule

// File: rtl/alu_arb.sv
// Arbitrates two requesters onto one external combinational ALU.
// One operation in flight: IDLE (accept) -> EXEC (drive ALU) -> RESP (hold result).
// An accept at edge T gives the consumer its first chance to take the
// response at edge T+2. Optional feature macro: ALU_ARB_ROUNDROBIN_EN.
module alu_arb
    import alu_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_sel,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_out,
    output logic             rsp0_carry,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_out,
    output logic             rsp1_carry,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry_out,
    output logic             busy
);

    state_t             state;
    state_t             state_nx;
    logic               gnt0;
    logic               gnt1;
    logic               take;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [SEL_W-1:0]   op_sel;
    logic               owner;
    logic [WIDTH-1:0]   res;
    logic               res_carry;

`ifdef ALU_ARB_ROUNDROBIN_EN
    logic               last;

    // Remember which requester won the most recent transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (take) begin
            last <= gnt1;
        end
    end
`endif

    alu_arb_pick u_pick (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
`ifdef ALU_ARB_ROUNDROBIN_EN
        .last   (last),
`endif
        .gnt0   (gnt0),
        .gnt1   (gnt1)
    );

    // A grant in IDLE is always a transfer since grants follow valids
    assign take = (state == IDLE) && !rst && (gnt0 || gnt1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (take) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (owner ? rsp1_ready : rsp0_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode; everything idles at zero
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp0_out   = '0;
        rsp1_out   = '0;
        rsp0_carry = 1'b0;
        rsp1_carry = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_sel    = '0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = gnt0 && !rst;
                req1_ready = gnt1 && !rst;
            end
            EXEC: begin
                busy    = 1'b1;
                alu_a   = op_a;
                alu_b   = op_b;
                alu_sel = op_sel;
            end
            RESP: begin
                busy = 1'b1;
                if (owner) begin
                    rsp1_valid = 1'b1;
                    rsp1_out   = res;
                    rsp1_carry = res_carry;
                end else begin
                    rsp0_valid = 1'b1;
                    rsp0_out   = res;
                    rsp0_carry = res_carry;
                end
            end
            default: ;
        endcase
    end

    // Operand capture on transfer, result capture at the end of EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a      <= '0;
            op_b      <= '0;
            op_sel    <= '0;
            owner     <= 1'b0;
            res       <= '0;
            res_carry <= 1'b0;
        end else begin
            if (take) begin
                op_a   <= gnt1 ? req1_a   : req0_a;
                op_b   <= gnt1 ? req1_b   : req0_b;
                op_sel <= gnt1 ? req1_sel : req0_sel;
                owner  <= gnt1;
            end
            if (state == EXEC) begin
                res       <= alu_out;
                res_carry <= alu_carry_out;
            end
        end
    end

endmodule

// File: tb/tb_alu_arb.sv
// Self-checking bench for alu_arb with a behavioural model of the shared ALU.
// Honours ALU_ARB_ROUNDROBIN_EN for the expected tie-break order.
module tb_alu_arb;
    import alu_arb_pkg::*;

    localparam int unsigned W = 4;
`ifdef ALU_ARB_ROUNDROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]   req0_sel, req1_sel;
    logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [W-1:0] rsp0_out, rsp1_out;
    logic         rsp0_carry, rsp1_carry;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic [1:0]   alu_sel;
    logic         alu_carry_out;
    logic         busy;

    int vectors = 0;
    int errors  = 0;
    int grants[$];

    alu_arb #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_out(rsp0_out), .rsp0_carry(rsp0_carry),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_out(rsp1_out), .rsp1_carry(rsp1_carry),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry_out(alu_carry_out),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result of one ALU operation: {carry, out}
    function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] sel);
        case (sel)
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_XOR:  return {1'b0, a ^ b};
            default: return {1'b0, a} + {1'b0, b};
        endcase
    endfunction

    // External shared ALU
    always_comb begin
        {alu_carry_out, alu_out} = ref_op(alu_a, alu_b, alu_sel);
    end

    task automatic apply_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Present one request; returns just after the negedge following acceptance
    task automatic send(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] sel, output bit acc, output int waits);
        acc = 1'b0;
        waits = -1;
        if (n == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
        end
        for (int k = 0; k < 8; k++) begin
            #1;
            acc = (n == 0) ? req0_ready : req1_ready;
            @(posedge clk);
            @(negedge clk);
            if (acc) begin
                waits = k;
                break;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 4'hF; req0_b = 4'hF; req0_sel = OP_ADD;
        req1_a = 4'hF; req1_b = 4'hF; req1_sel = OP_ADD;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, alu_a, alu_b, alu_sel,
             rsp0_out, rsp1_out, rsp0_carry, rsp1_carry} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b%b rspv=%b%b busy=%b alu=%h/%h/%h expected all 0",
                     req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, alu_a, alu_b, alu_sel);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_add();
        bit acc; int w;
        apply_reset();
        rsp0_ready = 1'b1;
        send(0, 4'b0011, 4'b0001, OP_ADD, acc, w);
        vectors++;
        if (acc !== 1'b1) begin
            errors++; $display("FAIL add_accept: accepted=%b expected 1", acc);
        end
        vectors++;
        if ({busy, rsp0_valid, alu_a, alu_b, alu_sel} !== {1'b1, 1'b0, 4'b0011, 4'b0001, OP_ADD}) begin
            errors++;
            $display("FAIL add_exec: busy=%b rsp0_valid=%b alu=%b/%b/%b expected 1 0 0011/0001/11",
                     busy, rsp0_valid, alu_a, alu_b, alu_sel);
        end
        @(negedge clk);
        vectors++;
        if ({rsp0_valid, rsp0_out, rsp0_carry, rsp1_valid, alu_a} !== {1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL add_resp: v=%b out=%b c=%b v1=%b alu_a=%b expected 1 0100 0 0 0000",
                     rsp0_valid, rsp0_out, rsp0_carry, rsp1_valid, alu_a);
        end
        @(negedge clk);
        vectors++;
        if ({busy, rsp0_valid} !== 2'b00) begin
            errors++; $display("FAIL add_done: busy=%b rsp0_valid=%b expected 0 0", busy, rsp0_valid);
        end
        rsp0_ready = 1'b0;
    endtask

    task automatic test_req1_carry();
        bit acc; int w;
        apply_reset();
        rsp1_ready = 1'b1;
        send(1, 4'b1111, 4'b0001, OP_ADD, acc, w);
        @(negedge clk);
        vectors++;
        if ({rsp1_valid, rsp1_out, rsp1_carry, rsp0_valid, rsp0_out, rsp0_carry}
                !== {1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL req1_carry: v1=%b out1=%b c1=%b v0=%b out0=%b c0=%b expected 1 0000 1 0 0000 0",
                     rsp1_valid, rsp1_out, rsp1_carry, rsp0_valid, rsp0_out, rsp0_carry);
        end
        @(negedge clk);
        rsp1_ready = 1'b0;
    endtask

    task automatic test_logic_ops();
        logic [W-1:0] ta[2] = '{4'b0100, 4'b1100};
        logic [W-1:0] tb[2] = '{4'b0010, 4'b1010};
        logic [1:0]   ts[2] = '{OP_AND, OP_OR};
        logic [W-1:0] te[2] = '{4'b0000, 4'b1110};
        bit acc; int w;
        apply_reset();
        rsp0_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({alu_a, alu_b, alu_sel} !== '0) begin
                errors++; $display("FAIL logic_alu_idle: alu=%h/%h/%h expected 0", alu_a, alu_b, alu_sel);
            end
            send(0, ta[i], tb[i], ts[i], acc, w);
            @(negedge clk);
            vectors++;
            if ({rsp0_valid, rsp0_out, rsp0_carry, alu_a, alu_b} !== {1'b1, te[i], 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL logic_op%0d: v=%b out=%b c=%b alu=%b/%b expected 1 %b 0 0000/0000",
                         i, rsp0_valid, rsp0_out, rsp0_carry, alu_a, alu_b, te[i]);
            end
            @(negedge clk);
        end
        rsp0_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit acc; int w;
        apply_reset();
        rsp0_ready = 1'b0;
        send(0, 4'b1100, 4'b1010, OP_XOR, acc, w);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            #1;
            vectors++;
            if ({rsp0_valid, rsp0_out, req0_ready, req1_ready, busy} !== {1'b1, 4'b0110, 1'b0, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL hold_cycle%0d: v=%b out=%b rdy=%b%b busy=%b expected 1 0110 00 1",
                         i, rsp0_valid, rsp0_out, req0_ready, req1_ready, busy);
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, rsp0_valid} !== 2'b00) begin
            errors++; $display("FAIL hold_release: busy=%b v=%b expected 0 0", busy, rsp0_valid);
        end
        rsp0_ready = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        bit acc; int w;
        apply_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        send(0, 4'b0101, 4'b0110, OP_ADD, acc, w);
        req0_valid = 1'b1; req1_valid = 1'b1;
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, alu_a, alu_b, alu_sel, req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== '0) begin
            errors++;
            $display("FAIL midreset_now: busy=%b alu=%h/%h/%h rdy=%b%b v=%b%b expected all 0",
                     busy, alu_a, alu_b, alu_sel, req0_ready, req1_ready, rsp0_valid, rsp1_valid);
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        send(1, 4'b0010, 4'b0011, OP_ADD, acc, w);
        vectors++;
        if (w !== 0) begin
            errors++; $display("FAIL midreset_first_accept: waits=%0d expected 0", w);
        end
        vectors++;
        if (rsp0_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_stale: rsp0_valid=%b expected 0", rsp0_valid);
        end
        @(negedge clk);
        vectors++;
        if ({rsp1_valid, rsp1_out, rsp1_carry, rsp0_valid} !== {1'b1, 4'b0101, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midreset_next: v1=%b out1=%b c1=%b v0=%b expected 1 0101 0 0",
                     rsp1_valid, rsp1_out, rsp1_carry, rsp0_valid);
        end
        @(negedge clk);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    // Cycle-level comparison against a transaction model; records DUT grants
    task automatic run_stream(input int ncyc, input bit force_valid, input int quota);
        bit           inflight = 1'b0;
        int           age = 0;
        int           owner = 0;
        bit           last = 1'b1;
        int           left0 = quota;
        int           left1 = quota;
        logic [W:0]   expres = '0;
        logic [W-1:0] ea = '0, eb = '0;
        logic [1:0]   es = '0;
        bit           v0, v1, ev0, ev1;
        int           eg, dg;
        grants.delete();
        for (int c = 0; c < ncyc; c++) begin
            v0 = force_valid ? (left0 > 0) : 1'($urandom_range(0, 1));
            v1 = force_valid ? (left1 > 0) : 1'($urandom_range(0, 1));
            req0_valid = v0; req0_a = W'($urandom); req0_b = W'($urandom); req0_sel = 2'($urandom);
            req1_valid = v1; req1_a = W'($urandom); req1_b = W'($urandom); req1_sel = 2'($urandom);
            rsp0_ready = force_valid ? 1'b1 : 1'($urandom_range(0, 1));
            rsp1_ready = force_valid ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            eg = -1;
            if (!inflight) begin
                if (v0 && v1)  eg = (RR && !last) ? 1 : 0;
                else if (v0)   eg = 0;
                else if (v1)   eg = 1;
            end
            ev0 = inflight && age >= 1 && owner == 0;
            ev1 = inflight && age >= 1 && owner == 1;
            vectors++;
            if ({req0_ready, req1_ready} !== {1'(eg == 0), 1'(eg == 1)}) begin
                errors++; $display("FAIL stream_ready c%0d: got %b%b expected grant %0d",
                                   c, req0_ready, req1_ready, eg);
            end
            vectors++;
            if ({busy, rsp0_valid, rsp1_valid} !== {inflight, ev0, ev1}) begin
                errors++; $display("FAIL stream_status c%0d: busy/v0/v1=%b%b%b expected %b%b%b",
                                   c, busy, rsp0_valid, rsp1_valid, inflight, ev0, ev1);
            end
            vectors++;
            if ({rsp0_carry, rsp0_out, rsp1_carry, rsp1_out} !==
                {(ev0 ? expres : 5'd0), (ev1 ? expres : 5'd0)}) begin
                errors++; $display("FAIL stream_data c%0d: r0=%b%b r1=%b%b expected result %b",
                                   c, rsp0_carry, rsp0_out, rsp1_carry, rsp1_out, expres);
            end
            vectors++;
            if ({alu_a, alu_b, alu_sel} !== ((inflight && age == 0) ? {ea, eb, es} : 10'd0)) begin
                errors++; $display("FAIL stream_alu c%0d: got %h/%h/%h expected %h/%h/%h (exec=%b)",
                                   c, alu_a, alu_b, alu_sel, ea, eb, es, inflight && age == 0);
            end
            dg = (req0_ready && v0) ? 0 : ((req1_ready && v1) ? 1 : -1);
            @(posedge clk);
            if (inflight) begin
                if (age >= 1 && ((owner == 0) ? rsp0_ready : rsp1_ready)) inflight = 1'b0;
                else age++;
            end else if (eg >= 0) begin
                inflight = 1'b1; age = 0; owner = eg;
                ea = (eg == 1) ? req1_a : req0_a;
                eb = (eg == 1) ? req1_b : req0_b;
                es = (eg == 1) ? req1_sel : req0_sel;
                expres = ref_op(ea, eb, es);
                if (RR) last = (eg == 1);
                if (eg == 0) left0--; else left1--;
            end
            if (dg >= 0) grants.push_back(dg);
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic test_tie_order();
        int exp_g;
        apply_reset();
        run_stream(30, 1'b1, 4);
        vectors++;
        if (grants.size() != 8) begin
            errors++; $display("FAIL tie_count: got %0d grants expected 8", grants.size());
        end
        for (int i = 0; i < grants.size() && i < 8; i++) begin
            exp_g = RR ? (i % 2) : ((i < 4) ? 0 : 1);
            vectors++;
            if (grants[i] != exp_g) begin
                errors++; $display("FAIL tie_grant%0d: got %0d expected %0d", i, grants[i], exp_g);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        run_stream(400, 1'b0, 0);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_sel = '0;
        req1_a = '0; req1_b = '0; req1_sel = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        test_reset();
        test_add();
        test_req1_carry();
        test_logic_ops();
        test_backpressure();
        test_reset_mid_exec();
        test_tie_order();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter: WIDTH, 4, operand/result width; SHALL equal the shared ALU width.
REQ-002 Port: clk  input  1  single clock; all state on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Ports: reqN_valid / reqN_ready  input / output  1  requester N (N=0,1) handshake.
REQ-005 Ports: reqN_a, reqN_b  input  WIDTH  operands; reqN_sel  input  2  op (00 AND, 01 OR, 10 XOR, 11 ADD).
REQ-006 Ports: rspN_valid  output  1, rspN_ready  input  1  response handshake to requester N.
REQ-007 Ports: rspN_out  output  WIDTH, rspN_carry  output  1  result and carry to requester N.
REQ-008 Ports: alu_a, alu_b  output  WIDTH, alu_sel  output  2  drive to shared combinational ALU.
REQ-009 Ports: alu_out  input  WIDTH, alu_carry_out  input  1  result from shared ALU.
REQ-010 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-011 FSM SHALL have states IDLE, EXEC, RESP.
REQ-012 IDLE: reqN_ready high only for the requester granted this cycle; other ready low.
REQ-013 Transfer on reqN_valid && reqN_ready; operands, sel, grant index registered; next state EXEC.
REQ-014 EXEC (exactly one cycle): alu_a/alu_b/alu_sel driven from registered operands; alu_out and alu_carry_out captured at end of cycle; next state RESP.
REQ-015 Outside EXEC, alu_a, alu_b, alu_sel SHALL be 0.
REQ-016 RESP: rspN_valid high only for granted N; rspN_out/rspN_carry stable until rspN_ready sampled high, then IDLE.
REQ-017 Latency: accept at edge T -> rspN_valid high from edge T+2; one operation in flight max; both reqN_ready low outside IDLE.
REQ-018 Non-granted rspN_out/rspN_carry SHALL be 0; rspN_carry for AND/OR/XOR SHALL be whatever ALU returns (0 expected), unmodified.
REQ-019 Arbitration: one valid -> that requester granted; both valid -> per REQ-024.
REQ-020 reqN_valid deasserted before transfer: no grant, no state change.

Reset
REQ-021 rst high SHALL immediately force IDLE, all outputs 0, last-grant pointer to 1 (so req0 wins first tie).
REQ-022 rst during EXEC or RESP SHALL discard the in-flight operation; no response issued after reset release.
REQ-023 First accept possible on first rising edge after rst deasserts.

Configuration
REQ-024 Macro ALU_ARB_ROUNDROBIN_EN defined: ties granted to the requester not granted last (pointer updates on every transfer); undefined: ties always granted to req0, pointer logic absent.

Structure
REQ-025 Package alu_arb_pkg SHALL hold op-select constants (OP_AND, OP_OR, OP_XOR, OP_ADD) and FSM state type.
REQ-026 Sub-module alu_arb_pick SHALL compute the grant from valids and pointer (combinational); ALU stays external.

Verification
REQ-027 req0 a=0011 b=0001 sel=11, rsp0_ready=1 -> rsp0_valid 2 cycles after accept, rsp0_out=0100, rsp0_carry=0.
REQ-028 req1 a=1111 b=0001 sel=11 -> rsp1_out=0000, rsp1_carry=1; rsp0_valid stays 0.
REQ-029 req0 and req1 both valid from reset, 4 ops each -> grants 0,1,0,1,... with ALU_ARB_ROUNDROBIN_EN; all req0 first without it.
REQ-030 req0 a=1100 b=1010 sel=10, rsp0_ready low 3 cycles -> rsp0_valid/rsp0_out=0110 held, req0_ready and req1_ready low, busy=1.
REQ-031 rst asserted mid-EXEC -> same-cycle outputs 0, busy=0; no rsp after release; next request served normally.
REQ-032 sel=00 a=0100 b=0010 -> out 0000; sel=01 a=1100 b=1010 -> out 1110; alu_a/alu_b=0 outside EXEC.
